// File: rtl/ccp_pkg.sv
// Shared coherence-protocol definitions: message type codes, MESI codes,
// message/MESI widths and the L1.5 controller FSM state type.
package ccp_pkg;

    localparam int MSG_WIDTH  = 4;
    localparam int MESI_WIDTH = 2;

    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_EMPTY        = 4'd0;
    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_LOAD_REQ     = 4'd1;
    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_STORE_REQ    = 4'd2;
    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_DATA_ACK     = 4'd3;
    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_INV_FWD      = 4'd4;
    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_STORE_FWD    = 4'd5;
    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_LOAD_FWD     = 4'd6;
    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_INV_FWDACK   = 4'd7;
    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_STORE_FWDACK = 4'd8;
    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_LOAD_FWDACK  = 4'd9;
    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_WB_REQ       = 4'd10;

    localparam logic [MESI_WIDTH-1:0] MESI_I = 2'd0;
    localparam logic [MESI_WIDTH-1:0] MESI_S = 2'd1;
    localparam logic [MESI_WIDTH-1:0] MESI_E = 2'd2;
    localparam logic [MESI_WIDTH-1:0] MESI_M = 2'd3;

    typedef enum logic {
        L15_IDLE      = 1'b0,
        L15_MISS_WAIT = 1'b1
    } l15_fsm_e;

endpackage

// File: rtl/l15_dm_cache_line_array.sv
// Line storage for the direct-mapped L1.5: NUM_SETS x {state, tag, data}.
// Ports: two combinational read ports (rd0 core, rd1 msg2), one write port; rst clears all.
module l15_line_array
    import ccp_pkg::*;
#(
    parameter int NUM_SETS = 4,
    parameter int IDX_W    = 2,
    parameter int TAG_W    = 6,
    parameter int DATA_W   = 8,
    parameter int MESI_W   = MESI_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd0_idx,
    output logic [MESI_W-1:0] rd0_state,
    output logic [TAG_W-1:0]  rd0_tag,
    output logic [DATA_W-1:0] rd0_data,
    input  logic [IDX_W-1:0]  rd1_idx,
    output logic [MESI_W-1:0] rd1_state,
    output logic [TAG_W-1:0]  rd1_tag,
    output logic [DATA_W-1:0] rd1_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [MESI_W-1:0] wr_state,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data
);

    logic [MESI_W-1:0] state_q [NUM_SETS];
    logic [MESI_W-1:0] state_d [NUM_SETS];
    logic [TAG_W-1:0]  tag_q   [NUM_SETS];
    logic [TAG_W-1:0]  tag_d   [NUM_SETS];
    logic [DATA_W-1:0] data_q  [NUM_SETS];
    logic [DATA_W-1:0] data_d  [NUM_SETS];

    assign rd0_state = state_q[rd0_idx];
    assign rd0_tag   = tag_q[rd0_idx];
    assign rd0_data  = data_q[rd0_idx];
    assign rd1_state = state_q[rd1_idx];
    assign rd1_tag   = tag_q[rd1_idx];
    assign rd1_data  = data_q[rd1_idx];

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            state_d[wr_idx] = wr_state;
            tag_d[wr_idx]   = wr_tag;
            data_d[wr_idx]  = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                state_q[i] <= MESI_W'(MESI_I);
                tag_q[i]   <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/l15_dm_cache.sv
// Direct-mapped private L1.5 cache controller (MESI per line) between core and L2.
// Ports: core valid/ready request + 1-cycle response; msg1 req out, msg2 in, msg3 ack/wb out.
module l15_dm_cache
    import ccp_pkg::*;
#(
    parameter int NUM_SETS = 4,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int MSG_W    = MSG_WIDTH,
    parameter int MESI_W   = MESI_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req_valid,
    output logic              core_req_ready,
    input  logic              core_req_st,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_resp_valid,
    output logic [DATA_W-1:0] core_resp_data,
    input  logic [MSG_W-1:0]  msg2_type,
    input  logic [ADDR_W-1:0] msg2_addr,
    input  logic [DATA_W-1:0] msg2_data,
    input  logic [MESI_W-1:0] mesi_send,
    output logic [MSG_W-1:0]  msg1_type,
    output logic [ADDR_W-1:0] msg1_addr,
    output logic [MSG_W-1:0]  msg3_type,
    output logic [ADDR_W-1:0] msg3_addr,
    output logic [DATA_W-1:0] msg3_data
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = ADDR_W - IDX_W;

    localparam logic [MSG_W-1:0] K_EMPTY     = MSG_W'(MSG_TYPE_EMPTY);
    localparam logic [MSG_W-1:0] K_LOAD_REQ  = MSG_W'(MSG_TYPE_LOAD_REQ);
    localparam logic [MSG_W-1:0] K_STORE_REQ = MSG_W'(MSG_TYPE_STORE_REQ);
    localparam logic [MSG_W-1:0] K_DATA_ACK  = MSG_W'(MSG_TYPE_DATA_ACK);
    localparam logic [MSG_W-1:0] K_INV_FWD   = MSG_W'(MSG_TYPE_INV_FWD);
    localparam logic [MSG_W-1:0] K_STORE_FWD = MSG_W'(MSG_TYPE_STORE_FWD);
    localparam logic [MSG_W-1:0] K_LOAD_FWD  = MSG_W'(MSG_TYPE_LOAD_FWD);
    localparam logic [MSG_W-1:0] K_INV_ACK   = MSG_W'(MSG_TYPE_INV_FWDACK);
    localparam logic [MSG_W-1:0] K_STORE_ACK = MSG_W'(MSG_TYPE_STORE_FWDACK);
    localparam logic [MSG_W-1:0] K_LOAD_ACK  = MSG_W'(MSG_TYPE_LOAD_FWDACK);
    localparam logic [MSG_W-1:0] K_WB_REQ    = MSG_W'(MSG_TYPE_WB_REQ);

    localparam logic [MESI_W-1:0] K_I = MESI_W'(MESI_I);
    localparam logic [MESI_W-1:0] K_S = MESI_W'(MESI_S);
    localparam logic [MESI_W-1:0] K_M = MESI_W'(MESI_M);

    l15_fsm_e fsm_q, fsm_d;

    logic              pend_st_q, pend_st_d;
    logic [DATA_W-1:0] pend_wdata_q, pend_wdata_d;
    logic [MSG_W-1:0]  msg1_type_q, msg1_type_d;
    logic [ADDR_W-1:0] msg1_addr_q, msg1_addr_d;
    logic [MSG_W-1:0]  msg3_type_q, msg3_type_d;
    logic [ADDR_W-1:0] msg3_addr_q, msg3_addr_d;
    logic [DATA_W-1:0] msg3_data_q, msg3_data_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;

    logic [IDX_W-1:0]  c_idx, m2_idx;
    logic [TAG_W-1:0]  c_tag, m2_tag;
    logic [MESI_W-1:0] rd0_state, rd1_state;
    logic [TAG_W-1:0]  rd0_tag, rd1_tag;
    logic [DATA_W-1:0] rd0_data, rd1_data;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [MESI_W-1:0] wr_state;
    logic [TAG_W-1:0]  wr_tag;
    logic [DATA_W-1:0] wr_data;

    logic m2_empty, is_inv, is_stf, is_ldf, is_fwd, is_ack;
    logic core_fire, c_hit, m2_hit;

    assign c_idx  = core_addr[IDX_W-1:0];
    assign c_tag  = core_addr[ADDR_W-1:IDX_W];
    assign m2_idx = msg2_addr[IDX_W-1:0];
    assign m2_tag = msg2_addr[ADDR_W-1:IDX_W];

    assign m2_empty = (msg2_type == K_EMPTY);
    assign is_inv   = (msg2_type == K_INV_FWD);
    assign is_stf   = (msg2_type == K_STORE_FWD);
    assign is_ldf   = (msg2_type == K_LOAD_FWD);
    assign is_fwd   = is_inv | is_stf | is_ldf;
    assign is_ack   = (msg2_type == K_DATA_ACK);

    // msg2 owns the cycle, so the core is held off whenever msg2 is busy
    assign core_req_ready = (fsm_q == L15_IDLE) && m2_empty;
    assign core_fire      = core_req_valid && core_req_ready;

    assign c_hit  = (rd0_state != K_I) && (rd0_tag == c_tag);
    assign m2_hit = (rd1_state != K_I) && (rd1_tag == m2_tag);

    l15_line_array #(
        .NUM_SETS (NUM_SETS),
        .IDX_W    (IDX_W),
        .TAG_W    (TAG_W),
        .DATA_W   (DATA_W),
        .MESI_W   (MESI_W)
    ) u_lines (
        .clk       (clk),
        .rst       (rst),
        .rd0_idx   (c_idx),
        .rd0_state (rd0_state),
        .rd0_tag   (rd0_tag),
        .rd0_data  (rd0_data),
        .rd1_idx   (m2_idx),
        .rd1_state (rd1_state),
        .rd1_tag   (rd1_tag),
        .rd1_data  (rd1_data),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_state  (wr_state),
        .wr_tag    (wr_tag),
        .wr_data   (wr_data)
    );

    always_comb begin
        fsm_d        = fsm_q;
        pend_st_d    = pend_st_q;
        pend_wdata_d = pend_wdata_q;
        msg1_type_d  = msg1_type_q;
        msg1_addr_d  = msg1_addr_q;
        msg3_type_d  = K_EMPTY;
        msg3_addr_d  = '0;
        msg3_data_d  = '0;
        resp_valid_d = 1'b0;
        resp_data_d  = '0;
        wr_en        = 1'b0;
        wr_idx       = m2_idx;
        wr_state     = rd1_state;
        wr_tag       = rd1_tag;
        wr_data      = rd1_data;

        if (is_fwd) begin
            // Ack even on tag mismatch; only a matching line changes state
            msg3_addr_d = msg2_addr;
            wr_en       = m2_hit;
            unique case (1'b1)
                is_inv: begin
                    msg3_type_d = K_INV_ACK;
                    wr_state    = K_I;
                end
                is_stf: begin
                    msg3_type_d = K_STORE_ACK;
                    msg3_data_d = rd1_data;
                    wr_state    = K_I;
                end
                default: begin
                    msg3_type_d = K_LOAD_ACK;
                    msg3_data_d = rd1_data;
                    wr_state    = K_S;
                end
            endcase
        end else if (is_ack && fsm_q == L15_MISS_WAIT) begin
            wr_en        = 1'b1;
            wr_tag       = m2_tag;
            wr_data      = pend_st_q ? pend_wdata_q : msg2_data;
            wr_state     = pend_st_q ? K_M : mesi_send;
            msg1_type_d  = K_EMPTY;
            msg1_addr_d  = '0;
            resp_valid_d = 1'b1;
            resp_data_d  = pend_st_q ? pend_wdata_q : msg2_data;
            fsm_d        = L15_IDLE;
        end else if (core_fire) begin
            wr_idx = c_idx;
            wr_tag = rd0_tag;
            wr_data = rd0_data;
            wr_state = rd0_state;
            if (c_hit && (!core_req_st || rd0_state != K_S)) begin
                resp_valid_d = 1'b1;
                if (core_req_st) begin
                    wr_en       = 1'b1;
                    wr_state    = K_M;
                    wr_data     = core_wdata;
                    resp_data_d = core_wdata;
                end else begin
                    resp_data_d = rd0_data;
                end
            end else begin
                msg1_type_d  = core_req_st ? K_STORE_REQ : K_LOAD_REQ;
                msg1_addr_d  = core_addr;
                pend_st_d    = core_req_st;
                pend_wdata_d = core_wdata;
                fsm_d        = L15_MISS_WAIT;
                // Dirty victim of a different tag goes back to L2 now
                if (!c_hit && rd0_state == K_M) begin
                    msg3_type_d = K_WB_REQ;
                    msg3_addr_d = {rd0_tag, c_idx};
                    msg3_data_d = rd0_data;
                    wr_en       = 1'b1;
                    wr_state    = K_I;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q        <= L15_IDLE;
            pend_st_q    <= 1'b0;
            pend_wdata_q <= '0;
            msg1_type_q  <= K_EMPTY;
            msg1_addr_q  <= '0;
            msg3_type_q  <= K_EMPTY;
            msg3_addr_q  <= '0;
            msg3_data_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            fsm_q        <= fsm_d;
            pend_st_q    <= pend_st_d;
            pend_wdata_q <= pend_wdata_d;
            msg1_type_q  <= msg1_type_d;
            msg1_addr_q  <= msg1_addr_d;
            msg3_type_q  <= msg3_type_d;
            msg3_addr_q  <= msg3_addr_d;
            msg3_data_q  <= msg3_data_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign msg1_type       = msg1_type_q;
    assign msg1_addr       = msg1_addr_q;
    assign msg3_type       = msg3_type_q;
    assign msg3_addr       = msg3_addr_q;
    assign msg3_data       = msg3_data_q;
    assign core_resp_valid = resp_valid_q;
    assign core_resp_data  = resp_data_q;

endmodule
